// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [2:0] LAST_DATA_BIT = 3'd7;

    // Clock cycles per bit; truncating division, so the line runs slightly fast.
    function automatic int unsigned bit_cyc(input int unsigned fclk, input int unsigned baud);
        return fclk / baud;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a one-byte holding register so the
// host can queue the next byte while the current frame is shifting out.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FCLK = 50_000_000,
    parameter int unsigned BAUD = 115_200
) (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned   BIT_CYC  = bit_cyc(FCLK, BAUD);
    localparam int unsigned   CW       = $clog2(BIT_CYC);
    localparam logic [CW-1:0] CNT_LOAD = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    uart_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end_s;
    logic          take_s;

    assign bit_end_s = (cnt_q == CNT_ZERO);

    // Next-state logic: FSM, width/bit counters, shift and holding registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        take_s      = 1'b0;

        if (!bit_end_s) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    take_s  = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_LOAD;
                    state_d = DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    cnt_d     = CNT_LOAD;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (bit_end_s && hold_full_q) begin
                    // Chain straight into the next start bit: no idle gap.
                    take_s  = 1'b1;
                    state_d = START;
                end else if (bit_end_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While full the host sees tx_ready=0, so a take and an accept never coincide.
        if (take_s) begin
            shift_d     = hold_q;
            bit_cnt_d   = 3'd0;
            cnt_d       = CNT_LOAD;
            hold_full_d = 1'b0;
        end else if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end else begin
            hold_full_d = hold_full_q;
        end
    end

    // Output decode from the next state so tx, tx_busy and tx_done are all flops.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (cnt_q == CNT_ONE);
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // State and datapath registers; reset forces the line idle at once.
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tx_ready = ~hold_full_q;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frames on the line are compared against
// bytes recorded at each handshake, using 8N1 framing rules computed here.
module tb_uart_tx;

    localparam int BIT_CYC  = 50_000_000 / 115_200;
    localparam int SLOW_CYC = 50_000_000 / 9_600;
    localparam int FRAME    = 10 * BIT_CYC;

    logic       clk50m = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx, tx_busy, tx_done;

    logic       slow_rst_n = 1'b0;
    logic [7:0] slow_data  = 8'h00;
    logic       slow_valid = 1'b0;
    logic       slow_ready, slow_tx, slow_busy, slow_done;

    int unsigned cyc = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int last_xfer_cyc = 0;
    logic [7:0] exp_q[$];
    int done_abs[$];

    uart_tx #(.FCLK(50_000_000), .BAUD(115_200)) dut (
        .clk50m(clk50m), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx #(.FCLK(50_000_000), .BAUD(9_600)) u_slow (
        .clk50m(clk50m), .rst_n(slow_rst_n), .tx_data(slow_data), .tx_valid(slow_valid),
        .tx_ready(slow_ready), .tx(slow_tx), .tx_busy(slow_busy), .tx_done(slow_done)
    );

    always #10 clk50m = ~clk50m;

    always @(posedge clk50m) cyc <= cyc + 1;

    // Offer one byte starting at a negedge; returns at the negedge after the transfer.
    task automatic drive_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        while (tx_ready !== 1'b1 && guard < 30 * BIT_CYC) begin
            @(negedge clk50m);
            guard++;
        end
        n_checks++;
        if (tx_ready !== 1'b1) $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, guard);
        else n_pass++;
        @(posedge clk50m);
        exp_q.push_back(b);
        @(negedge clk50m);
        last_xfer_cyc = cyc;
        n_checks++;
        if (tx_ready !== 1'b0) $display("FAIL ready_after_accept: tx_ready=%b, required 0", tx_ready);
        else n_pass++;
    endtask

    // Watch n frames on tx and compare each with the next recorded byte.
    task automatic monitor_frames(input int n, input bit contiguous);
        int last_end;
        last_end = 0;
        for (int f = 0; f < n; f++) begin
            logic [7:0] exp_b, got_b;
            logic [9:0] bits;
            int wait_n, good, busy_bad, done_cnt, done_pos, t_start, bi;
            wait_n = 0; good = 0; busy_bad = 0; done_cnt = 0; done_pos = -1; got_b = 8'h00;
            while (tx !== 1'b0 && wait_n < 40 * BIT_CYC) begin
                @(negedge clk50m);
                wait_n++;
            end
            n_checks++;
            if (tx !== 1'b0) begin
                $display("FAIL frame_start_timeout: frame %0d tx=%b, required start bit 0", f, tx);
                return;
            end else n_pass++;
            t_start = cyc;
            if (contiguous && f > 0) begin
                n_checks++;
                if (t_start !== last_end + 1) $display("FAIL frame_gap: frame %0d starts at %0d, required %0d", f, t_start, last_end + 1);
                else n_pass++;
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_frame: frame %0d with no byte accepted, required none", f);
                exp_b = 8'h00;
            end else begin
                n_pass++;
                exp_b = exp_q.pop_front();
            end
            bits = {1'b1, exp_b, 1'b0};
            for (int k = 0; k < FRAME; k++) begin
                if (k > 0) @(negedge clk50m);
                bi = k / BIT_CYC;
                if (tx === bits[bi]) good++;
                if (tx_busy !== 1'b1) busy_bad++;
                if (tx_done === 1'b1) begin
                    done_cnt++;
                    done_pos = k;
                    done_abs.push_back(cyc);
                end
                if (bi >= 1 && bi <= 8 && (k % BIT_CYC) == BIT_CYC / 2) got_b[bi-1] = tx;
            end
            last_end = cyc;
            n_checks++;
            if (got_b !== exp_b) $display("FAIL frame_data: frame %0d got %02h, required %02h", f, got_b, exp_b);
            else n_pass++;
            n_checks++;
            if (good !== FRAME) $display("FAIL frame_shape: frame %0d %0d cycles correct, required %0d", f, good, FRAME);
            else n_pass++;
            n_checks++;
            if (done_cnt !== 1 || done_pos !== FRAME - 1) $display("FAIL tx_done_pulse: frame %0d count %0d at %0d, required 1 at %0d", f, done_cnt, done_pos, FRAME - 1);
            else n_pass++;
            n_checks++;
            if (busy_bad !== 0) $display("FAIL tx_busy_frame: frame %0d %0d cycles not busy, required 0", f, busy_bad);
            else n_pass++;
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk50m);
        n_checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0) $display("FAIL idle_%s: tx=%b busy=%b, required tx=1 busy=0", tag, tx, tx_busy);
        else n_pass++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk50m);
        n_checks++;
        if (tx !== 1'b1) $display("FAIL reset_tx: got %b, required 1", tx); else n_pass++;
        n_checks++;
        if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", tx_ready); else n_pass++;
        n_checks++;
        if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", tx_busy); else n_pass++;
        n_checks++;
        if (tx_done !== 1'b0) $display("FAIL reset_done: got %b, required 0", tx_done); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk50m);
    endtask

    task automatic test_single;
        drive_byte(8'h55);
        tx_valid = 1'b0;
        @(negedge clk50m);
        n_checks++;
        if (tx !== 1'b0 || cyc !== last_xfer_cyc + 1) $display("FAIL start_latency: tx=%b at +%0d, required 0 at +1", tx, cyc - last_xfer_cyc);
        else n_pass++;
        monitor_frames(1, 1'b0);
        check_idle("single");
    endtask

    task automatic test_back_to_back;
        done_abs.delete();
        fork
            begin
                drive_byte(8'hA5);
                drive_byte(8'h3C);
                tx_valid = 1'b0;
            end
            monitor_frames(2, 1'b1);
        join
        n_checks++;
        if (done_abs.size() !== 2 || done_abs[1] - done_abs[0] !== FRAME)
            $display("FAIL done_spacing: %0d pulses, required 2 spaced %0d", done_abs.size(), FRAME);
        else n_pass++;
        check_idle("b2b");
    endtask

    task automatic test_backpressure;
        fork
            begin
                drive_byte(8'h00);
                drive_byte(8'hFF);
                drive_byte(8'h81);
                tx_valid = 1'b0;
            end
            monitor_frames(3, 1'b1);
        join
        check_idle("backpressure");
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL backpressure_leftover: %0d bytes unsent, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_random;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int gap;
                    gap = $urandom_range(0, 300);
                    repeat (gap) @(negedge clk50m);
                    drive_byte(8'($urandom_range(0, 255)));
                    tx_valid = 1'b0;
                end
            end
            monitor_frames(3, 1'b0);
        join
        check_idle("random");
    endtask

    task automatic test_reset_midframe;
        int done_seen, low_seen;
        done_seen = 0; low_seen = 0;
        drive_byte(8'h00);
        tx_valid = 1'b0;
        repeat (1000) @(negedge clk50m);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1)
            $display("FAIL reset_midframe: tx=%b busy=%b ready=%b, required 1 0 1", tx, tx_busy, tx_ready);
        else n_pass++;
        @(negedge clk50m);
        rst_n = 1'b1;
        exp_q.delete();
        for (int k = 0; k < 5 * BIT_CYC; k++) begin
            @(negedge clk50m);
            if (tx_done === 1'b1) done_seen++;
            if (tx !== 1'b1) low_seen++;
        end
        n_checks++;
        if (done_seen !== 0) $display("FAIL done_after_reset: %0d pulses, required 0", done_seen); else n_pass++;
        n_checks++;
        if (low_seen !== 0) $display("FAIL line_after_reset: %0d non-idle cycles, required 0", low_seen); else n_pass++;
    endtask

    task automatic test_slow_baud;
        int wait_n, len, busy_bad, done_seen;
        logic lvl;
        wait_n = 0; busy_bad = 0; done_seen = 0;
        slow_rst_n = 1'b1;
        @(negedge clk50m);
        slow_valid = 1'b1;
        slow_data  = 8'h55;
        @(negedge clk50m);
        slow_valid = 1'b0;
        while (slow_tx !== 1'b0 && wait_n < 100) begin
            @(negedge clk50m);
            wait_n++;
        end
        for (int p = 0; p < 3; p++) begin
            len = 0;
            lvl = slow_tx;
            while (slow_tx === lvl && len < 2 * SLOW_CYC) begin
                if (slow_busy !== 1'b1) busy_bad++;
                if (slow_done === 1'b1) done_seen++;
                @(negedge clk50m);
                len++;
            end
            n_checks++;
            if (len !== SLOW_CYC) $display("FAIL slow_bit_period: bit %0d lasted %0d, required %0d", p, len, SLOW_CYC);
            else n_pass++;
        end
        n_checks++;
        if (busy_bad !== 0 || done_seen !== 0) $display("FAIL slow_status: busy_bad=%0d done=%0d, required 0 0", busy_bad, done_seen);
        else n_pass++;
        slow_rst_n = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_midframe();
        test_slow_baud();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
